// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle-latency imem reads and presents {pc, inst} from a small FIFO.
// Optional IF_MISALIGN_CHECK_EN adds o_misaligned and halts on a misaligned redirect target.
module if_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_raddr,
    output logic        o_imem_ren,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_halted
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic        o_misaligned
`endif
);

    localparam int          PW  = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int          CW  = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t          state_reg;
    logic [31:0]     pc_reg;
    logic [31:0]     resp_addr_reg;
    logic            resp_pending_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [31:0]     slot_pc   [BUF_DEPTH];
    logic [31:0]     slot_inst [BUF_DEPTH];

    logic            running;
    logic            deq;
    logic            flush;
    logic            push;
    logic            ren;
    logic [CW-1:0]   credit_used;
    logic [31:0]     target_pc;
    logic            bad_target;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign running     = (state_reg == RUN);
    assign o_valid     = (count_reg != '0);
    assign deq         = o_valid & ~i_stall;
    assign flush       = running & (i_halt | i_redirect);
    // Slots already promised: buffered words plus the word in flight, minus the one leaving now.
    assign credit_used = count_reg + CW'(resp_pending_reg) - CW'(deq);
    assign ren         = running & (credit_used < CW'(BUF_DEPTH)) & ~i_redirect & ~i_halt;
    assign push        = resp_pending_reg & ~flush;

`ifdef IF_MISALIGN_CHECK_EN
    logic misaligned_reg;
    assign target_pc    = i_redirect_pc;
    assign bad_target   = |i_redirect_pc[1:0];
    assign o_misaligned = misaligned_reg;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^i_redirect_pc[1:0];
    assign target_pc       = {i_redirect_pc[31:2], 2'b00};
    assign bad_target      = 1'b0;
`endif

    assign o_imem_raddr = pc_reg;
    assign o_imem_ren   = ren;
    assign o_inst       = o_valid ? slot_inst[rd_ptr_reg] : NOP;
    assign o_pc         = o_valid ? slot_pc[rd_ptr_reg] : pc_reg;
    assign o_halted     = (state_reg == HALT);

    // Payload slots carry no reset: validity lives entirely in count_reg.
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
        logic [31:0] pc_reg_q;
        logic [31:0] inst_reg_q;
        always_ff @(posedge i_clk) begin
            if (push && (wr_ptr_reg == PW'(gi))) begin
                pc_reg_q   <= resp_addr_reg;
                inst_reg_q <= i_imem_rdata;
            end
        end
        assign slot_pc[gi]   = pc_reg_q;
        assign slot_inst[gi] = inst_reg_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg        <= BOOT;
            pc_reg           <= RESET_ADDR;
            resp_addr_reg    <= RESET_ADDR;
            resp_pending_reg <= 1'b0;
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            count_reg        <= '0;
`ifdef IF_MISALIGN_CHECK_EN
            misaligned_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                BOOT: state_reg <= RUN;
                RUN: begin
                    if (i_halt) begin
                        state_reg        <= HALT;
                        resp_pending_reg <= 1'b0;
                        rd_ptr_reg       <= '0;
                        wr_ptr_reg       <= '0;
                        count_reg        <= '0;
                    end else if (i_redirect) begin
                        pc_reg           <= target_pc;
                        resp_pending_reg <= 1'b0;
                        rd_ptr_reg       <= '0;
                        wr_ptr_reg       <= '0;
                        count_reg        <= '0;
                        if (bad_target) begin
                            state_reg <= HALT;
`ifdef IF_MISALIGN_CHECK_EN
                            misaligned_reg <= 1'b1;
`endif
                        end
                    end else begin
                        if (ren) begin
                            pc_reg        <= pc_reg + 32'd4;
                            resp_addr_reg <= pc_reg;
                        end
                        resp_pending_reg <= ren;
                        if (push) wr_ptr_reg <= bump(wr_ptr_reg);
                        if (deq)  rd_ptr_reg <= bump(rd_ptr_reg);
                        count_reg <= count_reg + CW'(push) - CW'(deq);
                    end
                end
                HALT: state_reg <= HALT;
                default: state_reg <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run against a stream-level model.
module tb_if_stage;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam int          BUF_DEPTH  = 2;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] raddr;
    logic        ren;
    logic [31:0] rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        halted;
`ifdef IF_MISALIGN_CHECK_EN
    logic        misaligned;
`endif

    int checks = 0;
    int errors = 0;

    // Stream-level model state
    logic [31:0] exp_pc;
    logic [31:0] fetch_pc;
    int          out_cnt;
    bit          halted_exp;
    bit          boot_exp;
    bit          hold_prev;
    bit          misaligned_exp;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    int          retired;

    if_stage #(.RESET_ADDR(RESET_ADDR), .BUF_DEPTH(BUF_DEPTH)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_raddr  (raddr),
        .o_imem_ren    (ren),
        .i_imem_rdata  (rdata),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_halt        (halt),
        .o_valid       (valid),
        .o_inst        (inst),
        .o_pc          (pc),
        .o_halted      (halted)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .o_misaligned  (misaligned)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    always @(posedge clk) if (ren) rdata <= memf(raddr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Per-cycle model checks, then advance the model across the coming edge.
    task automatic observe();
        logic deq;
        int   nxt;
        deq = valid && !stall;
        if (!valid) chk("idle_inst", inst, NOP);
        else begin
            chk("inst_matches_pc", inst, memf(pc));
            chk1("valid_has_credit", out_cnt > 0, 1'b1);
        end
        if (hold_prev) begin
            chk("stall_hold_pc", pc, prev_pc);
            chk("stall_hold_inst", inst, prev_inst);
        end
        chk1("halted_flag", halted, halted_exp);
`ifdef IF_MISALIGN_CHECK_EN
        chk1("misaligned_flag", misaligned, misaligned_exp);
`endif
        if (boot_exp) chk1("boot_no_fetch", ren, 1'b0);
        if (halted_exp) begin
            chk1("halt_valid", valid, 1'b0);
            chk1("halt_ren", ren, 1'b0);
        end
        if (redirect || halt) chk1("flush_cycle_ren", ren, 1'b0);
        if (ren) chk("fetch_addr", raddr, fetch_pc);
        nxt = out_cnt + int'(ren) - int'(deq);
        chk1("credit_bound", nxt <= BUF_DEPTH, 1'b1);
        if (deq && !halted_exp) begin
            chk("retire_pc", pc, exp_pc);
            exp_pc = exp_pc + 32'd4;
            retired++;
        end
        hold_prev = valid && stall && !redirect && !halt;
        prev_pc   = pc;
        prev_inst = inst;
        if (halted_exp || boot_exp) begin
            boot_exp = 1'b0;
        end else if (halt) begin
            halted_exp = 1'b1;
            out_cnt    = 0;
        end else if (redirect) begin
            out_cnt = 0;
`ifdef IF_MISALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                halted_exp     = 1'b1;
                misaligned_exp = 1'b1;
            end
            exp_pc   = redirect_pc;
            fetch_pc = redirect_pc;
`else
            exp_pc   = redirect_pc & ~32'd3;
            fetch_pc = redirect_pc & ~32'd3;
`endif
        end else begin
            out_cnt = nxt;
            if (ren) fetch_pc = fetch_pc + 32'd4;
        end
    endtask

    task automatic adv();
        observe();
        @(negedge clk);
    endtask

    task automatic step();
        #1;
        adv();
    endtask

    // Reset asserted between edges so the outputs must respond without a clock.
    task automatic do_reset();
        #2;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
        #1;
        chk1("rst_ren", ren, 1'b0);
        chk1("rst_valid", valid, 1'b0);
        chk("rst_inst", inst, NOP);
        chk("rst_pc", pc, RESET_ADDR);
        chk("rst_raddr", raddr, RESET_ADDR);
        chk1("rst_halted", halted, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = RESET_ADDR; fetch_pc = RESET_ADDR; out_cnt = 0;
        halted_exp = 1'b0; boot_exp = 1'b1; hold_prev = 1'b0; misaligned_exp = 1'b0;
    endtask

    initial begin
        int start_retired;
        retired = 0;
        @(negedge clk);
        do_reset();

        // Boot and first fetches
        #1; chk1("boot_ren", ren, 1'b0); adv();
        #1; chk1("first_ren", ren, 1'b1); chk("first_addr", raddr, 32'h0); adv();
        #1; chk("second_addr", raddr, 32'h4); chk1("not_yet_valid", valid, 1'b0); adv();
        #1; chk1("first_valid", valid, 1'b1); chk("first_pc", pc, 32'h0); chk("first_inst", inst, 32'h1); adv();
        #1; chk("second_pc", pc, 32'h4); chk("second_inst", inst, 32'h2); adv();
        repeat (3) step();

        // Stall for 5 cycles mid-stream
        stall = 1'b1;
        step(); step();
        #1; chk1("stall_full_ren", ren, 1'b0); chk1("stall_valid", valid, 1'b1); adv();
        step(); step();
        stall = 1'b0;
        repeat (6) step();

        // Redirect while the fetch of 0x8 is in flight
        do_reset();
        step(); step(); step(); step();
        redirect = 1'b1; redirect_pc = 32'h100;
        #1; chk1("redirect_ren", ren, 1'b0); adv();
        redirect = 1'b0;
        #1; chk1("refetch_ren", ren, 1'b1); chk("refetch_addr", raddr, 32'h100); chk1("flushed_valid", valid, 1'b0); adv();
        step();
        #1; chk1("target_valid", valid, 1'b1); chk("target_pc", pc, 32'h100); adv();
        repeat (3) step();

        // Redirect while downstream is stalled
        stall = 1'b1;
        repeat (4) step();
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        step(); step();
        #1; chk1("stalled_target_valid", valid, 1'b1); chk("stalled_target_pc", pc, 32'h100); adv();
        stall = 1'b0;
        repeat (3) step();

        // PC wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        step(); step();
        #1; chk("wrap_pc0", pc, 32'hFFFF_FFF8); adv();
        #1; chk("wrap_pc1", pc, 32'hFFFF_FFFC); adv();
        #1; chk("wrap_pc2", pc, 32'h0000_0000); adv();
        repeat (2) step();

        // Halt together with redirect: halt wins
        halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        #1; chk1("halt_cycle_ren", ren, 1'b0); adv();
        halt = 1'b0; redirect = 1'b0;
        #1; chk1("halted_next", halted, 1'b1); chk1("halted_no_valid", valid, 1'b0); adv();
        for (int i = 0; i < 20; i++) begin
            stall = 1'($urandom_range(1));
            redirect = ($urandom_range(3) == 0);
            redirect_pc = $urandom & ~32'd3;
            #1; chk1("halt_hold_valid", valid, 1'b0); chk1("halt_hold_ren", ren, 1'b0); adv();
        end
        do_reset();
        #1; chk1("restart_boot_ren", ren, 1'b0); adv();
        #1; chk1("restart_ren", ren, 1'b1); chk("restart_addr", raddr, RESET_ADDR); chk1("restart_halted", halted, 1'b0); adv();

`ifdef IF_MISALIGN_CHECK_EN
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        #1; chk1("mis_flag", misaligned, 1'b1); chk1("mis_halted", halted, 1'b1);
        chk1("mis_valid", valid, 1'b0); chk("mis_raddr", raddr, 32'h102); adv();
        do_reset();
        step();
`endif

        // Randomized run against the model
        start_retired = retired;
        for (int i = 0; i < 1500; i++) begin
            stall = ($urandom_range(2) == 0);
            redirect = ($urandom_range(49) == 0);
`ifdef IF_MISALIGN_CHECK_EN
            redirect_pc = $urandom & ~32'd3;
`else
            redirect_pc = $urandom;
`endif
            step();
        end
        stall = 1'b0; redirect = 1'b0;
        repeat (4) step();
        chk1("random_progress", (retired - start_retired) > 400, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
